// File: rtl/aes_arb_pkg.sv
// Shared types and constants for aes_enc_arbiter.
// Used by the arbiter top and by rr_arbiter.
package aes_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        RUN    = 2'd2,
        RESEED = 2'd3
    } arb_state_e;

    localparam int BLK_W = 128;

    function automatic int share_w(input int d);
        return BLK_W * d;
    endfunction

    // Index width for NREQ requesters, never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the search starts at i_ptr and wraps.
// Returns a one-hot grant, its binary index and an any-request flag.
module rr_arbiter
    import aes_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int OW   = owner_w(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [OW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [OW-1:0]   o_idx,
    output logic            o_any
);

    logic [OW-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = OW'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/aes_enc_arbiter.sv
// Shares one masked AES-128 core between NREQ requesters, one job in flight.
// Optional reseed policy: define AES_ARB_RESEED_POLICY_EN.
module aes_enc_arbiter
    import aes_arb_pkg::*;
#(
    parameter  int d            = 2,
    parameter  int NREQ         = 2,
    parameter  int RESEED_LIMIT = 1024,
    localparam int W            = share_w(d)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_plaintext,
    input  logic [NREQ*W-1:0] req_key,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [W-1:0]      resp_ciphertext,
    input  logic              seed_valid,
    output logic              seed_ready,
    output logic              core_in_valid,
    input  logic              core_in_ready,
    output logic [W-1:0]      core_plaintext,
    output logic [W-1:0]      core_key,
    input  logic              core_out_valid,
    output logic              core_out_ready,
    input  logic [W-1:0]      core_ciphertext,
    output logic              core_seed_valid,
    input  logic              core_seed_ready,
    output logic              reseed_req,
    output logic              busy
);

    localparam int OW = owner_w(NREQ);

    arb_state_e      r_state;
    logic [OW-1:0]   r_ptr;
    logic [OW-1:0]   r_owner;
    logic [NREQ-1:0] r_own_oh;

    logic [NREQ-1:0] w_grant;
    logic [OW-1:0]   w_idx;
    logic [OW-1:0]   w_next;
    logic            w_any;
    logic            w_limit;
    logic            w_in_hs;
    logic            w_out_hs;
    logic            w_seed_hs;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_next = (w_idx == OW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    assign w_in_hs   = (r_state == SEND) && core_in_ready;
    assign w_out_hs  = (r_state == RUN) && core_out_valid
                     && |(resp_ready & r_own_oh);
    assign w_seed_hs = (r_state == RESEED) && seed_valid && core_seed_ready;

`ifdef AES_ARB_RESEED_POLICY_EN
    localparam int CW = $clog2(RESEED_LIMIT + 1);

    logic [CW-1:0] r_cnt;

    assign w_limit = (r_cnt == CW'(RESEED_LIMIT));

    // Saturates at the limit; only a completed seed transfer clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_seed_hs) begin
            r_cnt <= '0;
        end else if (w_in_hs && !w_limit) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign reseed_req = w_limit
                      && ((r_state == IDLE) || (r_state == RESEED));
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (RESEED_LIMIT > 0);
    assign w_limit      = 1'b0;
    assign reseed_req   = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_own_oh <= NREQ'(1);
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (seed_valid) begin
                        r_state <= RESEED;
                    end else if (!w_limit && w_any) begin
                        r_state  <= SEND;
                        r_owner  <= w_idx;
                        r_own_oh <= w_grant;
                        r_ptr    <= w_next;
                    end
                end
                SEND: begin
                    if (w_in_hs) r_state <= RUN;
                end
                RUN: begin
                    if (w_out_hs) r_state <= IDLE;
                end
                RESEED: begin
                    if (core_seed_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign core_in_valid   = (r_state == SEND);
    assign req_ready       = w_in_hs ? r_own_oh : '0;
    assign resp_valid      = ((r_state == RUN) && core_out_valid)
                           ? r_own_oh : '0;
    assign core_out_ready  = (r_state == RUN) && |(resp_ready & r_own_oh);
    assign core_seed_valid = (r_state == RESEED) && seed_valid;
    assign seed_ready      = (r_state == RESEED) && core_seed_ready;
    assign busy            = (r_state != IDLE);

    assign core_plaintext  = req_plaintext[int'(r_owner)*W +: W];
    assign core_key        = req_key[int'(r_owner)*W +: W];
    assign resp_ciphertext = core_ciphertext;

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Directed bench: stub masked core, behavioural arbiter model checked
// every negedge, plus literal expectations for the directed scenarios.
module tb_aes_enc_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 256;
`ifdef AES_ARB_RESEED_POLICY_EN
    localparam int LIM  = 2;
`else
    localparam int LIM  = 1024;
`endif

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1      = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] KEY1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [NREQ*W-1:0] req_plaintext, req_key;
    logic [W-1:0]      resp_ciphertext, core_plaintext, core_key;
    logic [W-1:0]      core_ciphertext;
    logic              seed_valid, seed_ready;
    logic              core_in_valid, core_in_ready;
    logic              core_out_valid, core_out_ready;
    logic              core_seed_valid, core_seed_ready;
    logic              reseed_req, busy;

    always #5 clk = ~clk;

    aes_enc_arbiter #(.d(2), .NREQ(NREQ), .RESEED_LIMIT(LIM)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_plaintext   (req_plaintext),
        .req_key         (req_key),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_ciphertext (resp_ciphertext),
        .seed_valid      (seed_valid),
        .seed_ready      (seed_ready),
        .core_in_valid   (core_in_valid),
        .core_in_ready   (core_in_ready),
        .core_plaintext  (core_plaintext),
        .core_key        (core_key),
        .core_out_valid  (core_out_valid),
        .core_out_ready  (core_out_ready),
        .core_ciphertext (core_ciphertext),
        .core_seed_valid (core_seed_valid),
        .core_seed_ready (core_seed_ready),
        .reseed_req      (reseed_req),
        .busy            (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] enc(input logic [127:0] v,
                                         input logic [127:0] m);
        return {m, v ^ m};
    endfunction

    function automatic logic [127:0] rec(input logic [W-1:0] s);
        return s[127:0] ^ s[255:128];
    endfunction

    // Stand-in for AES: exact on the FIPS-197 vector, keyed mix otherwise.
    function automatic logic [127:0] cipher(input logic [127:0] p,
                                            input logic [127:0] k);
        if (p == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return p ^ {k[63:0], k[127:64]} ^ 128'hc3;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        return NREQ'(1) << i;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int s);
        for (int k = 0; k < NREQ; k++)
            if (v[(s + k) % NREQ]) return (s + k) % NREQ;
        return -1;
    endfunction

    // Stub core: fixed latency, fresh output mask per result.
    int           lat;
    logic [127:0] ct_hold;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_out_valid  <= 1'b0;
            core_ciphertext <= '0;
            lat             <= 0;
        end else begin
            if (core_out_valid && core_out_ready) core_out_valid <= 1'b0;
            if (core_in_valid && core_in_ready) begin
                lat     <= 3;
                ct_hold <= cipher(rec(core_plaintext), rec(core_key));
            end else if (lat > 0) begin
                lat <= lat - 1;
                if (lat == 1) begin
                    core_out_valid  <= 1'b1;
                    core_ciphertext <= enc(ct_hold, {$urandom(), $urandom(),
                                                     $urandom(), $urandom()});
                end
            end
        end
    end

    // Behavioural model: transaction-level view of the arbiter.
    int              inflight = 0, rr_next = 0, exp_own = 0, n_enc = 0;
    int              n_seed = 0, e;
    logic            prev_civ = 1'b0;
    logic [NREQ-1:0] prev_rv = '0;
    logic [127:0]    exp_ct;
    int              grant_log[$];

    always @(negedge clk) begin
        if (rst) begin
            inflight = 0;
            rr_next  = 0;
            n_enc    = 0;
            prev_civ = 1'b0;
            prev_rv  = '0;
        end else begin
`ifdef AES_ARB_RESEED_POLICY_EN
            chk("reseed_req", reseed_req,
                n_enc >= LIM && inflight == 0 && !core_in_valid);
`else
            chk("reseed_req", reseed_req, 0);
`endif
            chk("busy", busy,
                inflight == 1 || core_in_valid || core_seed_valid);
            if (core_in_valid && !prev_civ) begin
                e = rr_pick(prev_rv, rr_next);
                chk("rr_has_candidate", e >= 0, 1);
                chk("grant_under_limit", n_enc < LIM, 1);
                if (e >= 0) begin
                    chk("core_pt_mux", core_plaintext, req_plaintext[e*W +: W]);
                    chk("core_key_mux", core_key, req_key[e*W +: W]);
                    exp_own = e;
                    rr_next = (e + 1) % NREQ;
                end
            end
            if (core_in_valid)
                chk("req_ready", req_ready,
                    core_in_ready ? onehot(exp_own) : '0);
            else
                chk("req_ready_idle", req_ready, 0);
            if (inflight == 1) begin
                chk("resp_valid", resp_valid,
                    core_out_valid ? onehot(exp_own) : '0);
                chk("core_out_ready", core_out_ready, resp_ready[exp_own]);
                if (core_out_valid && core_out_ready) begin
                    chk("resp_ct", rec(resp_ciphertext), exp_ct);
                    inflight = 0;
                end
            end else begin
                chk("resp_valid_idle", resp_valid, 0);
                chk("core_out_ready_idle", core_out_ready, 0);
            end
            if (core_in_valid && core_in_ready) begin
                chk("one_in_flight", inflight, 0);
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i]) grant_log.push_back(i);
                exp_ct = cipher(rec(req_plaintext[exp_own*W +: W]),
                                rec(req_key[exp_own*W +: W]));
                inflight = 1;
                n_enc    = (n_enc < LIM) ? n_enc + 1 : n_enc;
            end
            if (core_seed_valid) begin
                chk("seed_no_overlap", inflight == 0 && !core_in_valid, 1);
                chk("seed_ready_fwd", seed_ready, core_seed_ready);
                if (core_seed_ready) begin
                    n_seed++;
                    n_enc = 0;
                end
            end else begin
                chk("seed_ready_idle", seed_ready, 0);
            end
            prev_civ = core_in_valid;
            prev_rv  = req_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grants(input int n);
        int t = 0;
        while (grant_log.size() < n && t < 300) begin
            tick();
            t++;
        end
        chk("grant_timeout", grant_log.size() >= n, 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            tick();
            t++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk(nm, {req_ready, resp_valid, core_in_valid, core_out_ready,
                 core_seed_valid, seed_ready, reseed_req, busy}, 0);
        chk({nm, "_mux0"}, core_plaintext, req_plaintext[W-1:0]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t, n0, s0;
        rst             = 1'b1;
        req_valid       = '0;
        resp_ready      = '1;
        seed_valid      = 1'b0;
        core_in_ready   = 1'b1;
        core_seed_ready = 1'b1;
        req_plaintext   = {enc(PT1, 128'h5555aaaa0f0f1234),
                           enc(FIPS_PT, 128'h13579bdf2468ace0)};
        req_key         = {enc(KEY1, 128'h0badf00d),
                           enc(FIPS_KEY, 128'hfeedface12345678)};
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_state");
        rst = 1'b0;
        tick();

        // FIPS vector from requester 0, one-cycle grant latency
        req_valid = 2'b01;
        @(negedge clk);
        chk("t1_no_grant_yet", core_in_valid, 0);
        tick();
        chk("t1_grant_latency", {core_in_valid, busy}, 2'b11);
        wait_grants(1);
        req_valid = '0;
        chk("t1_owner", grant_log[0], 0);
        t = 0;
        while (resp_valid == '0 && t < 50) begin
            tick();
            t++;
        end
        chk("t1_resp_only0", resp_valid, 2'b01);
        chk("t1_fips_ct", rec(resp_ciphertext), FIPS_CT);
        wait_idle();

        // Both requesters held: strict alternation from pointer 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        grant_log.delete();
        req_valid = 2'b11;
        wait_grants(4);
        req_valid = '0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_order_%0d", i), grant_log[i], i % 2);
        wait_idle();

        // Seed and request in the same idle cycle: seed goes first
        n0 = grant_log.size();
        s0 = n_seed;
        seed_valid = 1'b1;
        req_valid  = 2'b10;
        tick();
        chk("t3_reseed_first", {core_seed_valid, core_in_valid, seed_ready},
            3'b101);
        tick();
        seed_valid = 1'b0;
        chk("t3_idle_after_seed", {busy, core_in_valid}, 2'b00);
        tick();
        chk("t3_grant_after_seed", core_in_valid, 1);
        wait_grants(n0 + 1);
        req_valid = '0;
        chk("t3_owner1", grant_log[n0], 1);
        chk("t3_one_seed", n_seed, s0 + 1);
        wait_idle();

        // Owner 0 refuses its result; owner re-request loses to waiter
        n0 = grant_log.size();
        resp_ready = 2'b10;
        req_valid  = 2'b01;
        wait_grants(n0 + 1);
        req_valid = 2'b11;
        t = 0;
        while (!core_out_valid && t < 50) begin
            tick();
            t++;
        end
        repeat (10) begin
            tick();
            chk("t4_stall", {core_out_ready, core_in_valid, busy, resp_valid},
                5'b00101);
        end
        resp_ready = 2'b11;
        wait_grants(n0 + 2);
        req_valid = '0;
        chk("t4_owner0", grant_log[n0], 0);
        chk("t4_waiter_wins", grant_log[n0 + 1], 1);
        wait_idle();

`ifdef AES_ARB_RESEED_POLICY_EN
        // Limit of 2: third request stalls until a seed completes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n0 = grant_log.size();
        req_valid = 2'b01;
        wait_grants(n0 + 2);
        wait_idle();
        repeat (4) begin
            tick();
            chk("t5_blocked", {reseed_req, core_in_valid, busy}, 3'b100);
        end
        seed_valid = 1'b1;
        tick();
        chk("t5_reseed", {core_seed_valid, reseed_req}, 2'b11);
        tick();
        seed_valid = 1'b0;
        chk("t5_cleared", {reseed_req, busy}, 2'b00);
        tick();
        chk("t5_third_grant", core_in_valid, 1);
        wait_grants(n0 + 3);
        req_valid = '0;
        wait_idle();
`endif

        // Reset mid-RUN, pointer must restart at 0
        n0 = grant_log.size();
        req_valid = 2'b01;
        wait_grants(n0 + 1);
        req_valid = '0;
        tick();
        chk("t6_in_run", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 2'b11;
        wait_grants(n0 + 2);
        req_valid = '0;
        chk("t6_ptr_zero", grant_log[n0 + 1], 0);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
